diferenca_pipe: RTL and testbench
=================================

// Module: diferenca_pipe
// PURPOSE
//  Pipelined, parametrised absolute-difference unit: S = |A - B| plus sign flag, WIDTH-bit operands.
//  Adds valid/ready flow control and a SAD mode (sum of |A-B| over a burst, closed by 'last').
//  Sits between operand sources and result consumers; replaces the 4-bit combinational difference datapath.
// PARAMETERS
//  WIDTH   8   operand width (A, B), >= 2
//  ACC_W   16  result/accumulator width, >= WIDTH; S zero-extended in mode 0
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      reset, asynchronous assert, active-low
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit can accept a beat; transfer when in_valid & in_ready
//  A          in   WIDTH  minuend, unsigned
//  B          in   WIDTH  subtrahend, unsigned
//  mode       in   1      0 = per-beat |A-B|, 1 = accumulate (SAD); sampled per beat
//  last       in   1      mode 1 only: closes the burst; ignored in mode 0
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts; transfer when out_valid & out_ready
//  S          out  ACC_W  |A-B| (mode 0) or burst sum (mode 1)
//  sinal      out  1      mode 0: 1 iff A < B; mode 1: always 0
//  overflow   out  1      mode 1: 1 iff burst sum saturated; mode 0: 0
// BEHAVIOUR
//  Reset (rst_n=0, async): both stage valids=0, accumulator=0, acc_ovf=0; out_valid=0, S=0, sinal=0,
//   overflow=0; in_ready=1 from the first cycle after release (pipeline empty). Reset mid-burst
//   discards the partial sum and any in-flight beats.
//  Stage 1 (register on accepted beat): d = A - B in WIDTH+1 bits; lt = borrow (A < B);
//   store mag = lt ? (~d[WIDTH-1:0] + 1) : d[WIDTH-1:0], plus lt, mode, last.
//   A == B -> mag=0, lt=0. Full-scale: A=0,B=2^WIDTH-1 -> mag=2^WIDTH-1, lt=1.
//  Stage 2 (output register):
//   mode 0: S <= {0, mag}, sinal <= lt, overflow <= 0, out_valid <= 1. Latency: 2 cycles accept->out_valid.
//   mode 1, last=0: acc <= sat(acc + mag); no output produced; stage-1 slot freed.
//   mode 1, last=1: S <= sat(acc + mag), overflow <= acc_ovf | carry, sinal <= 0, out_valid <= 1;
//    acc and acc_ovf cleared in the same edge. Single-beat burst (first beat has last=1) -> S = mag.
//   sat(x): if x >= 2^ACC_W then 2^ACC_W-1 and acc_ovf <= 1 (sticky until burst closes).
//  Flow control: stage 2 advances when !out_valid | out_ready; stage 1 advances when stage 2 advances
//   or stage 1 holds a mode-1/last=0 beat (consumed by accumulator, needs no output slot).
//   in_ready = !s1_valid | s1_advance (combinational from out_ready; no combinational in_valid->in_ready).
//   Full throughput 1 beat/cycle with out_ready=1. While out_valid & !out_ready: S, sinal, overflow,
//   out_valid held stable; at most 2 beats in flight; no beat lost or duplicated.
//  Mixed modes: mode-0 beats interleaved within an open burst pass through unchanged; accumulator untouched.
//  Results emerge in acceptance order (excluding absorbed mode-1/last=0 beats).
// STRUCTURE
//  Package diferenca_pkg: MODE_ABS=1'b0, MODE_SAD=1'b1 constants; typedef of stage-1 payload
//   struct {mag, lt, mode, last} parametrised via WIDTH.
//  Sub-module abs_diff_core (combinational, WIDTH param): A, B -> mag, lt; the only
//   subtract/negate logic; instantiated once in stage 1. Accumulate/saturate logic stays in top.
// TESTING (WIDTH=8, ACC_W=16 unless stated; out_ready=1 unless stated)
//  1. Reset release then mode 0 beats (3,10),(200,55),(0x5A,0x5A),(0,255) back-to-back
//     -> S=7/1, 145/0, 0/0, 255/1 (S/sinal), each 2 cycles after accept, 1 per cycle, overflow=0.
//  2. Mode 1 burst (10,3),(3,10),(255,0,last) -> exactly one output S=269, sinal=0, overflow=0;
//     next burst (1,0,last) -> S=1 (accumulator cleared).
//  3. ACC_W=10: mode 1, five beats (255,0), last on 5th -> S=1023, overflow=1; following
//     single-beat burst (4,1,last) -> S=3, overflow=0.
//  4. Backpressure: out_ready=0 for 6 cycles, in_valid=1 mode 0 -> in_ready drops after 2 accepts,
//     S/out_valid stable while stalled; on release all beats delivered in order, none dropped.
//  5. Mixed: mode 1 (5,2), mode 0 (1,9), mode 1 (7,0,last) -> outputs S=8/sinal=1 then S=10/sinal=0.
//  6. rst_n pulsed low mid-burst and with out_valid=1 -> outputs 0 immediately (async);
//     next burst (2,6,last) -> S=4, stale partial sum not included.

Source files
------------

// File: rtl/diferenca_pkg.sv
// Shared constants and the stage-1 payload type for the absolute-difference / SAD pipeline.
package diferenca_pkg;

    localparam logic MODE_ABS = 1'b0;
    localparam logic MODE_SAD = 1'b1;

    // Upper bound on WIDTH; the payload carries mag zero-extended to this width.
    localparam int MAG_MAX_W = 32;

    typedef struct packed {
        logic [MAG_MAX_W-1:0] mag;
        logic                 lt;
        logic                 mode;
        logic                 last;
    } s1_payload_t;

endpackage

// File: rtl/abs_diff_core.sv
// Combinational |a - b| with borrow flag; the only subtract/negate logic in the unit.
module abs_diff_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] mag,
    output logic             lt
);

    logic [WIDTH:0] d;

    assign d   = {1'b0, a} - {1'b0, b};
    assign lt  = d[WIDTH];
    assign mag = lt ? (~d[WIDTH-1:0] + WIDTH'(1)) : d[WIDTH-1:0];

endmodule

// File: rtl/diferenca_pipe.sv
// Two-stage |A-B| unit with valid/ready flow control and a saturating SAD accumulate mode.
module diferenca_pipe
    import diferenca_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mode,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] S,
    output logic             sinal,
    output logic             overflow
);

    localparam int SUM_W = ((ACC_W > MAG_MAX_W) ? ACC_W : MAG_MAX_W) + 1;

    function automatic logic [ACC_W-1:0] sat_acc(input logic [SUM_W-1:0] x);
        return (|x[SUM_W-1:ACC_W]) ? {ACC_W{1'b1}} : x[ACC_W-1:0];
    endfunction

    logic [WIDTH-1:0] core_mag;
    logic             core_lt;
    s1_payload_t      payload_p1;
    logic             vld_p1;
    logic [ACC_W-1:0] acc;
    logic             acc_ovf;
    logic [SUM_W-1:0] sum_p1;
    logic             carry_p1;
    logic             absorb_p1;
    logic             s1_adv;
    logic             s2_adv;
    logic             accept;

    abs_diff_core #(.WIDTH(WIDTH)) u_core (
        .a   (A),
        .b   (B),
        .mag (core_mag),
        .lt  (core_lt)
    );

    assign sum_p1    = SUM_W'(acc) + SUM_W'(payload_p1.mag);
    assign carry_p1  = |sum_p1[SUM_W-1:ACC_W];
    // Open-burst SAD beats drain into the accumulator without needing an output slot.
    assign absorb_p1 = vld_p1 && (payload_p1.mode == MODE_SAD) && !payload_p1.last;
    assign s2_adv    = !out_valid || out_ready;
    assign s1_adv    = s2_adv || absorb_p1;
    assign in_ready  = !vld_p1 || s1_adv;
    assign accept    = in_valid && in_ready;

    // Stage 1: register magnitude, borrow and beat control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            payload_p1 <= '{mag: MAG_MAX_W'(core_mag), lt: core_lt, mode: mode, last: last};
        end
    end

    // Stage 2: output register and burst accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            S         <= '0;
            sinal     <= 1'b0;
            overflow  <= 1'b0;
            acc       <= '0;
            acc_ovf   <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid <= vld_p1 && !absorb_p1;
                if (vld_p1 && !absorb_p1) begin
                    if (payload_p1.mode == MODE_ABS) begin
                        S        <= ACC_W'(payload_p1.mag);
                        sinal    <= payload_p1.lt;
                        overflow <= 1'b0;
                    end else begin
                        S        <= sat_acc(sum_p1);
                        sinal    <= 1'b0;
                        overflow <= acc_ovf | carry_p1;
                    end
                end
            end
            if (vld_p1 && s1_adv && (payload_p1.mode == MODE_SAD)) begin
                if (payload_p1.last) begin
                    acc     <= '0;
                    acc_ovf <= 1'b0;
                end else begin
                    acc     <= sat_acc(sum_p1);
                    acc_ovf <= acc_ovf | carry_p1;
                end
            end
        end
    end

endmodule

// File: tb/tb_diferenca_pipe.sv
// Bench for diferenca_pipe: directed vector table, saturation/stall/reset sequences, random stream vs reference model.
module tb_diferenca_pipe;

    localparam int WIDTH = 8;
    localparam int ACC_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             mode = 1'b0;
    logic             last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] S;
    logic             sinal;
    logic             overflow;

    always #5 clk = ~clk;

    diferenca_pipe #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .mode      (mode),
        .last      (last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .sinal     (sinal),
        .overflow  (overflow)
    );

    typedef struct {
        logic [15:0] s;
        logic        sg;
        logic        ov;
    } exp_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        m;
        logic        l;
        logic        has;
        logic [15:0] s;
        logic        sg;
        logic        ov;
    } vec_t;

    exp_t        exp_q[$];
    int          lat_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          accept_cnt = 0;
    int          acc_m = 0;
    bit          use_model = 0;
    bit          chk_lat = 0;
    bit          stop_rnd = 0;
    logic        stall_prev = 1'b0;
    logic [15:0] s_prev;
    logic        sg_prev;
    logic        ov_prev;
    exp_t        e;
    int          lat;

    vec_t tbl[12];
    vec_t stall_v[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic void model_beat(input logic [7:0] a, input logic [7:0] b,
                                       input logic m, input logic l);
        int d;
        d = (int'(a) > int'(b)) ? int'(a) - int'(b) : int'(b) - int'(a);
        if (!m) begin
            exp_q.push_back('{s: 16'(d), sg: (a < b), ov: 1'b0});
        end else begin
            acc_m += d;
            if (l) begin
                exp_q.push_back('{s: (acc_m > 65535) ? 16'hFFFF : 16'(acc_m), sg: 1'b0, ov: (acc_m > 65535)});
                acc_m = 0;
            end
        end
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            lat_q.delete();
            acc_m = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_S", 32'(S), 32'(s_prev));
                chk("hold_sinal", 32'(sinal), 32'(sg_prev));
                chk("hold_overflow", 32'(overflow), 32'(ov_prev));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_S", 32'(S), 32'(e.s));
                    chk("out_sinal", 32'(sinal), 32'(e.sg));
                    chk("out_overflow", 32'(overflow), 32'(e.ov));
                end
                if (lat_q.size() > 0) begin
                    lat = lat_q.pop_front();
                    if (chk_lat) chk("latency", 32'(cyc - lat), 32'd2);
                end
            end
            if (in_valid && in_ready) begin
                accept_cnt++;
                if (!mode || last) lat_q.push_back(cyc);
                if (use_model) model_beat(A, B, mode, last);
            end
            stall_prev = out_valid && !out_ready;
            s_prev     = S;
            sg_prev    = sinal;
            ov_prev    = overflow;
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic m, input logic l);
        int n = 0;
        A = a; B = b; mode = m; last = l; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] s, input logic sg, input logic ov);
        exp_q.push_back('{s: s, sg: sg, ov: ov});
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_sinal", 32'(sinal), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int acc0;

        tbl[0]  = '{8'd3,   8'd10,  1'b0, 1'b0, 1'b1, 16'd7,   1'b1, 1'b0};
        tbl[1]  = '{8'd200, 8'd55,  1'b0, 1'b0, 1'b1, 16'd145, 1'b0, 1'b0};
        tbl[2]  = '{8'h5A,  8'h5A,  1'b0, 1'b0, 1'b1, 16'd0,   1'b0, 1'b0};
        tbl[3]  = '{8'd0,   8'd255, 1'b0, 1'b0, 1'b1, 16'd255, 1'b1, 1'b0};
        tbl[4]  = '{8'd10,  8'd3,   1'b1, 1'b0, 1'b0, 16'd0,   1'b0, 1'b0};
        tbl[5]  = '{8'd3,   8'd10,  1'b1, 1'b0, 1'b0, 16'd0,   1'b0, 1'b0};
        tbl[6]  = '{8'd255, 8'd0,   1'b1, 1'b1, 1'b1, 16'd269, 1'b0, 1'b0};
        tbl[7]  = '{8'd1,   8'd0,   1'b1, 1'b1, 1'b1, 16'd1,   1'b0, 1'b0};
        tbl[8]  = '{8'd5,   8'd2,   1'b1, 1'b0, 1'b0, 16'd0,   1'b0, 1'b0};
        tbl[9]  = '{8'd1,   8'd9,   1'b0, 1'b0, 1'b1, 16'd8,   1'b1, 1'b0};
        tbl[10] = '{8'd7,   8'd0,   1'b1, 1'b1, 1'b1, 16'd10,  1'b0, 1'b0};
        tbl[11] = '{8'd6,   8'd6,   1'b0, 1'b1, 1'b1, 16'd0,   1'b0, 1'b0};

        stall_v[0] = '{8'd9,   8'd4,   1'b0, 1'b0, 1'b1, 16'd5,   1'b0, 1'b0};
        stall_v[1] = '{8'd1,   8'd8,   1'b0, 1'b0, 1'b1, 16'd7,   1'b1, 1'b0};
        stall_v[2] = '{8'd100, 8'd100, 1'b0, 1'b0, 1'b1, 16'd0,   1'b0, 1'b0};
        stall_v[3] = '{8'd255, 8'd0,   1'b0, 1'b0, 1'b1, 16'd255, 1'b0, 1'b0};
        stall_v[4] = '{8'd17,  8'd200, 1'b0, 1'b0, 1'b1, 16'd183, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_S", 32'(S), 32'd0);
        chk("reset_sinal", 32'(sinal), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors: abs mode, SAD bursts, mixed modes
        chk_lat = 1;
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].has) push_exp(tbl[i].s, tbl[i].sg, tbl[i].ov);
            send(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].l);
        end
        drain();
        chk_lat = 0;

        // Saturation boundary: 257*255 fits exactly, 258*255 saturates
        push_exp(16'hFFFF, 1'b0, 1'b0);
        for (int k = 0; k < 257; k++) send(8'd255, 8'd0, 1'b1, k == 256);
        push_exp(16'hFFFF, 1'b0, 1'b1);
        for (int k = 0; k < 258; k++) send(8'd255, 8'd0, 1'b1, k == 257);
        push_exp(16'd3, 1'b0, 1'b0);
        send(8'd4, 8'd1, 1'b1, 1'b1);
        drain();

        // Backpressure
        acc0 = accept_cnt;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) push_exp(stall_v[i].s, stall_v[i].sg, stall_v[i].ov);
                for (int i = 0; i < 5; i++) send(stall_v[i].a, stall_v[i].b, stall_v[i].m, stall_v[i].l);
            end
            begin
                repeat (6) @(negedge clk);
                chk("stall_accepts", 32'(accept_cnt - acc0), 32'd2);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_out_valid", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_total_accepts", 32'(accept_cnt - acc0), 32'd5);

        // Reset mid-burst, then with a stalled result held on the output
        send(8'd5, 8'd0, 1'b1, 1'b0);
        send(8'd6, 8'd1, 1'b1, 1'b0);
        pulse_reset();
        out_ready = 1'b0;
        send(8'd3, 8'd1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
        pulse_reset();
        out_ready = 1'b1;
        push_exp(16'd4, 1'b0, 1'b0);
        send(8'd2, 8'd6, 1'b1, 1'b1);
        drain();

        // Random stream against the reference model
        use_model = 1;
        acc_m = 0;
        stop_rnd = 0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(8'($urandom), 8'($urandom), $urandom_range(0, 2) != 0,
                         $urandom_range(0, 3) == 0);
                end
                send(8'($urandom), 8'($urandom), 1'b1, 1'b1);
                stop_rnd = 1;
            end
            begin
                while (!stop_rnd) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
